// File: rtl/store_buffer.sv
// store_buffer
//   Posted-store queue in front of the data memory. Word stores from the
//   pipeline are queued and drained to memory in any cycle without a load.
//   Younger loads see buffered data through word-address forwarding.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   st_valid/st_addr/st_data   store request; accepted when st_ready is high
//   st_ready                   buffer not full (from registered count only)
//   ld_valid/ld_addr/ld_funct3 load request (000 = LB, anything else = LW)
//   ld_data                    final load data (combinational, same cycle)
//   mem_read/mem_write/mem_addr/mem_wd/mem_funct3  data memory controls
//   mem_rd                     data memory read data
//   sb_empty                   no stores pending
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  input  logic [DM_ADDRESS-1:0] st_addr,
  input  logic [DATA_W-1:0]     st_data,
  output logic                  st_ready,
  input  logic                  ld_valid,
  input  logic [DM_ADDRESS-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd,
  output logic                  sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = DM_ADDRESS - 2;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LW = 3'b010;

  logic [WA_W-1:0]   ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;

  logic              enq, drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_word;
  logic [PTR_W-1:0]  fwd_idx;

  // Byte offsets are meaningless for full-word stores and word forwarding.
  logic unused_low_bits;
  assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready = (count != FULL_COUNT);
  assign sb_empty = (count == '0);
  assign enq      = st_valid && st_ready;
  // Loads own the memory port; a drain only happens in a load-free cycle.
  assign drain    = !ld_valid && !sb_empty;

  // Memory-port arbitration.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_funct3 = '0;
    if (ld_valid) begin
      mem_read   = 1'b1;
      mem_addr   = ld_addr;
      mem_funct3 = ld_funct3;
    end else if (drain) begin
      mem_write  = 1'b1;
      mem_addr   = {ent_addr[head], 2'b00};
      mem_wd     = ent_data[head];
      mem_funct3 = F3_LW;
    end
  end

  // Forwarding: walk oldest to youngest so the last match (nearest tail) wins.
  // The store arriving this cycle is not yet in the array, so it never forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_word = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == ld_addr[DM_ADDRESS-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_word = ent_data[fwd_idx];
      end
    end
  end

  // On a miss the memory has already sign-extended an LB, so mem_rd passes as-is.
  always_comb begin
    ld_data = mem_rd;
    if (ld_valid && fwd_hit) begin
      if (ld_funct3 == F3_LB) ld_data = {{(DATA_W-8){fwd_word[7]}}, fwd_word[7:0]};
      else                    ld_data = fwd_word;
    end
  end

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // enq and drain never target the same slot: drain needs count>0, enq needs count<DEPTH.
      if (enq) begin
        tail            <= tail + 1'b1;
        ent_valid[tail] <= 1'b1;
      end
      if (drain) begin
        head            <= head + 1'b1;
        ent_valid[head] <= 1'b0;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array has no reset; ent_valid alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= st_addr[DM_ADDRESS-1:2];
      ent_data[tail] <= st_data;
    end
  end

endmodule
